// File: rtl/corr_pkg.sv
// Shared definitions for the correlation peak search and the downstream
// correlation-index register: FSM state encoding and index width.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } corr_state_t;

  // Index width: enough to hold N = samples*osf, plus one spare MSB.
  function automatic int unsigned corr_iw(input int unsigned samples,
                                          input int unsigned osf);
    return $clog2(samples * osf) + 1;
  endfunction

  localparam int unsigned CORR_IW_DEFAULT = corr_iw(128, 8);

endpackage

// File: rtl/correlation_peak_search.sv
// Searches a window of N = SAMPLES*OSF correlation magnitudes for its maximum.
// Optional feature macro: CORR_PEAK_THRESHOLD_EN (adds Threshold / NoPeak).
module correlation_peak_search
  import corr_pkg::*;
#(
  parameter int unsigned SAMPLES = 128,
  parameter int unsigned OSF     = 8,
  parameter int unsigned DW      = 16,
  localparam int unsigned N      = SAMPLES * OSF,
  localparam int unsigned IW     = corr_iw(SAMPLES, OSF)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Valid,
  input  logic [DW-1:0] Corr,
`ifdef CORR_PEAK_THRESHOLD_EN
  input  logic [DW-1:0] Threshold,
  output logic          NoPeak,
`endif
  output logic          Busy,
  output logic          LD,
  output logic [IW-1:0] PeakIndex,
  output logic [DW-1:0] PeakValue
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  corr_state_t   state, state_next;
  logic [IW-1:0] cnt, max_idx, new_idx;
  logic [DW-1:0] max_val, new_val;
  logic          accept, last, take, pass, ld_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    unique case (state)
      IDLE:    if (Start) state_next = SEARCH;
      SEARCH: begin
        Busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final sample is folded into the result in the same cycle it is
  // accepted, so the peak registers are already valid during DONE.
  always_comb begin
    accept  = (state == SEARCH) && Valid;
    last    = accept && (cnt == LAST);
    take    = accept && ((cnt == '0) || (Corr > max_val));
    new_val = take ? Corr : max_val;
    new_idx = take ? cnt : max_idx;
`ifdef CORR_PEAK_THRESHOLD_EN
    pass    = (new_val >= Threshold);
`else
    pass    = 1'b1;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      ld_q      <= 1'b0;
      PeakIndex <= '0;
      PeakValue <= '0;
`ifdef CORR_PEAK_THRESHOLD_EN
      NoPeak    <= 1'b0;
`endif
    end else begin
      ld_q <= last && pass;
`ifdef CORR_PEAK_THRESHOLD_EN
      NoPeak <= last && !pass;
`endif
      if ((state == IDLE) && Start) cnt <= '0;
      else if (accept)              cnt <= cnt + 1'b1;
      if (accept) begin
        max_val <= new_val;
        max_idx <= new_idx;
      end
      if (last && pass) begin
        PeakIndex <= new_idx;
        PeakValue <= new_val;
      end
    end
  end

  assign LD = ld_q;

endmodule

// File: tb/tb_correlation_peak_search.sv
// Self-checking bench for correlation_peak_search (SAMPLES=4, OSF=2, DW=16).
// Covers the threshold option when CORR_PEAK_THRESHOLD_EN is defined.
module tb_correlation_peak_search;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Valid = 1'b0;
  logic [15:0] Corr = '0;
  logic        Busy, LD;
  logic [3:0]  PeakIndex;
  logic [15:0] PeakValue;
`ifdef CORR_PEAK_THRESHOLD_EN
  logic [15:0] Threshold = '0;
  logic        NoPeak;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0][15:0] data;
    int               gap;
    int               restart;
    bit               valid_with_start;
    bit               start_in_done;
    logic [3:0]       exp_idx;
    logic [15:0]      exp_val;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  correlation_peak_search #(
    .SAMPLES(4),
    .OSF    (2),
    .DW     (16)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Valid    (Valid),
    .Corr     (Corr),
`ifdef CORR_PEAK_THRESHOLD_EN
    .Threshold(Threshold),
    .NoPeak   (NoPeak),
`endif
    .Busy     (Busy),
    .LD       (LD),
    .PeakIndex(PeakIndex),
    .PeakValue(PeakValue)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7,
                              input int gap, input int restart,
                              input bit vws, input bit sid,
                              input logic [3:0] idx, input logic [15:0] val);
    vec_t v;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    v.data[4] = d4; v.data[5] = d5; v.data[6] = d6; v.data[7] = d7;
    v.gap = gap;
    v.restart = restart;
    v.valid_with_start = vws;
    v.start_in_done = sid;
    v.exp_idx = idx;
    v.exp_val = val;
    return v;
  endfunction

  // Scoreboard: every LD must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && LD === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ld: got LD=1 want no strobe at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("peak_index", 32'(PeakIndex), 32'(e.idx));
        check("peak_value", 32'(PeakValue), 32'(e.val));
      end
    end
  end

  task automatic run_window(input vec_t v, input bit exp_nopeak);
    exp_t e;
    if (!exp_nopeak) begin
      e.idx = v.exp_idx;
      e.val = v.exp_val;
      sb.push_back(e);
    end
    @(posedge Clk); #1;
    Start = 1'b1;
    if (v.valid_with_start) begin
      Valid = 1'b1;
      Corr  = 16'hffff;
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Valid = 1'b1;
      Corr  = v.data[i];
      Start = (i == v.restart);
      @(negedge Clk);
      check("busy_search", 32'(Busy), 32'd1);
      check("ld_early", 32'(LD), 32'd0);
      @(posedge Clk); #1;
      Start = 1'b0;
      Valid = 1'b0;
      if (i != 7) begin
        for (int g = 0; g < v.gap; g++) begin
          @(negedge Clk);
          check("busy_gap", 32'(Busy), 32'd1);
          @(posedge Clk); #1;
        end
      end
    end
    Start = v.start_in_done;
    @(negedge Clk);
    check("ld_strobe", 32'(LD), exp_nopeak ? 32'd0 : 32'd1);
    check("busy_done", 32'(Busy), 32'd1);
`ifdef CORR_PEAK_THRESHOLD_EN
    check("nopeak_done", 32'(NoPeak), 32'(exp_nopeak));
`endif
    if (exp_nopeak) begin
      check("held_index", 32'(PeakIndex), 32'(v.exp_idx));
      check("held_value", 32'(PeakValue), 32'(v.exp_val));
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    check("ld_after", 32'(LD), 32'd0);
    check("busy_after", 32'(Busy), 32'd0);
`ifdef CORR_PEAK_THRESHOLD_EN
    check("nopeak_after", 32'(NoPeak), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1, 2, 3, 4, 5, 6, 7, 8,         0, -1, 0, 0, 4'd7, 16'd8);
    tbl[1] = mk(5, 9, 3, 9, 2, 1, 0, 4,         0, -1, 0, 0, 4'd1, 16'd9);
    tbl[2] = mk(1, 2, 3, 4, 5, 6, 7, 8,         2, -1, 0, 0, 4'd7, 16'd8);
    tbl[3] = mk(8, 7, 6, 5, 4, 3, 2, 1,         0, -1, 0, 0, 4'd0, 16'd8);
    tbl[4] = mk(1, 2, 3, 4, 5, 6, 7, 8,         0,  4, 0, 0, 4'd7, 16'd8);
    tbl[5] = mk(3, 3, 3, 3, 3, 3, 3, 3,         0, -1, 1, 0, 4'd0, 16'd3);
    tbl[6] = mk(100, 200, 300, 400, 50, 60, 70, 70, 0, -1, 0, 1, 4'd3, 16'd400);
    tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 16'hffff,  0, -1, 0, 0, 4'd7, 16'hffff);

    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ld", 32'(LD), 32'd0);
    check("rst_index", 32'(PeakIndex), 32'd0);
    check("rst_value", 32'(PeakValue), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (tbl[k]) run_window(tbl[k], 1'b0);

    // Reset mid-window: outputs clear at once and no strobe follows.
    @(posedge Clk); #1;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Valid = 1'b1;
      Corr  = 16'(20 + i);
      @(posedge Clk); #1;
    end
    Valid = 1'b0;
    Reset = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_ld", 32'(LD), 32'd0);
    check("midrst_index", 32'(PeakIndex), 32'd0);
    check("midrst_value", 32'(PeakValue), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    check("idle_after_rst", 32'(Busy), 32'd0);
    run_window(tbl[3], 1'b0);

`ifdef CORR_PEAK_THRESHOLD_EN
    run_window(tbl[1], 1'b0);
    Threshold = 16'd10;
    begin
      vec_t h;
      h = tbl[0];
      h.exp_idx = 4'd1;
      h.exp_val = 16'd9;
      run_window(h, 1'b1);
    end
    Threshold = 16'd8;
    run_window(tbl[0], 1'b0);
    Threshold = 16'd0;
`endif

    repeat (3) @(posedge Clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/correlation_peak_search.md
CORRELATION_PEAK_SEARCH -- requirements
Module: correlation_peak_search

Interface
REQ-001 SHALL have parameter SAMPLES, default 128, symbols per correlation window.
REQ-002 SHALL have parameter OSF, default 8, oversampling factor; window length N = SAMPLES*OSF.
REQ-003 SHALL have parameter DW, default 16, unsigned correlation magnitude width.
REQ-004 SHALL define IW = $clog2(SAMPLES*OSF)+1, identical to the downstream correlation-index register width.
REQ-005 SHALL have port Clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 SHALL have port Reset, input, 1, asynchronous and active-high.
REQ-007 SHALL have port Start, input, 1, single-cycle pulse that opens a search window.
REQ-008 SHALL have port Valid, input, 1, qualifies Corr.
REQ-009 SHALL have port Corr, input, DW, correlation magnitude sample.
REQ-010 SHALL have port Busy, output, 1, high while a window is open.
REQ-011 SHALL have port LD, output, 1, single-cycle load strobe for the downstream index register.
REQ-012 SHALL have port PeakIndex, output, IW, sample index of the window maximum.
REQ-013 SHALL have port PeakValue, output, DW, magnitude of the window maximum.

Function
REQ-014 SHALL implement FSM IDLE -> SEARCH -> DONE -> IDLE.
REQ-015 IDLE: Start=1 SHALL move to SEARCH, clear sample counter; a Valid in the Start cycle SHALL NOT be accepted.
REQ-016 SEARCH: each Valid=1 cycle SHALL accept Corr at counter value cnt (0..N-1), then increment cnt.
REQ-017 Running max SHALL be replaced when cnt==0 or Corr > max (strict); ties keep the earliest index.
REQ-018 Accepting the sample at cnt==N-1 SHALL move to DONE; no further samples accepted.
REQ-019 DONE: LD=1 for exactly one cycle, the cycle after the last sample; PeakIndex/PeakValue valid in that cycle; next state IDLE.
REQ-020 PeakIndex/PeakValue SHALL update only together with LD and hold until the next LD.
REQ-021 Busy SHALL be 1 in SEARCH and DONE, 0 in IDLE.
REQ-022 Start in SEARCH or DONE SHALL be ignored; Valid in IDLE or DONE SHALL be ignored.
REQ-023 Valid gaps in SEARCH SHALL only stall; no timeout.
REQ-024 PeakIndex SHALL be zero-extended cnt (MSB of IW always 0 for in-range indices).

Reset
REQ-025 Reset=1 SHALL immediately force IDLE, cnt=0, running max=0, LD=0, Busy=0, PeakIndex=0, PeakValue=0.
REQ-026 Reset mid-SEARCH SHALL abandon the window without LD; next Start begins a fresh window.

Configuration
REQ-027 Macro CORR_PEAK_THRESHOLD_EN SHALL add input Threshold (DW) and output NoPeak (1, reset 0).
REQ-028 With macro: in DONE, if max < Threshold, NoPeak=1 for one cycle, LD stays 0, PeakIndex/PeakValue hold; else behaviour per REQ-019.
REQ-029 Without macro: neither port exists; LD always issued in DONE.

Structure
REQ-030 Package corr_pkg SHALL hold the FSM state enum and the IW width function/constant shared with the index register.
REQ-031 Implementation SHALL be a single module; no sub-modules.

Verification (SAMPLES=4, OSF=2: N=8, IW=4, DW=16)
REQ-032 Start, then Corr 1..8 on consecutive Valid -> LD one cycle after 8th sample, PeakIndex=7, PeakValue=8, Busy falls with LD.
REQ-033 Corr 5,9,3,9,2,1,0,4 -> PeakIndex=1, PeakValue=9 (earliest tie).
REQ-034 Same data as REQ-032 with Valid low 2 cycles between samples -> identical result, Busy high throughout.
REQ-035 Reset asserted after 3 samples -> Busy=0, PeakIndex=0 immediately, no LD; new window of 8,7..1 -> PeakIndex=0, PeakValue=8.
REQ-036 Start re-pulsed after 4th sample -> ignored; LD after 8th sample as normal.
REQ-037 With CORR_PEAK_THRESHOLD_EN, Threshold=10, data 1..8 -> NoPeak one cycle, LD=0, PeakIndex held at prior value.
